// File: rtl/fnd_pkg.sv
// Shared constants for the six-digit 7-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-high, a = bit 6.
package fnd_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  localparam logic [2:0] SLOT_SEC_ONE  = 3'd0;
  localparam logic [2:0] SLOT_SEC_TEN  = 3'd1;
  localparam logic [2:0] SLOT_MIN_ONE  = 3'd2;
  localparam logic [2:0] SLOT_MIN_TEN  = 3'd3;
  localparam logic [2:0] SLOT_HOUR_ONE = 3'd4;
  localparam logic [2:0] SLOT_HOUR_TEN = 3'd5;

  localparam logic [5:0] ENB_ALL_OFF = 6'b111111;

endpackage

// File: rtl/fnd_scan_drv_if.sv
// Bundle of the BCD/enable inputs and digit-drive outputs of the scan driver.
// master = time/blink source plus display sink, slave = the scan driver itself.
interface fnd_scan_drv_if;

  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       dis_hour;
  logic       dis_min;
  logic       dis_sec;
  logic [6:0] seg;
  logic       seg_dp;
  logic [5:0] seg_enb;

  modport master (
    output hour_bcd, min_bcd, sec_bcd, dis_hour, dis_min, dis_sec,
    input  seg, seg_dp, seg_enb
  );

  modport slave (
    input  hour_bcd, min_bcd, sec_bcd, dis_hour, dis_min, dis_sec,
    output seg, seg_dp, seg_enb
  );

endinterface

// File: rtl/seg7_dec.sv
// BCD nibble to 7-segment pattern; nibbles 10..15 show a dash.
module seg7_dec
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan_drv.sv
// Six-digit HH:MM:SS common-anode scan driver with per-field blanking.
// Optional FND_LEAD_ZERO_BLANK_EN blanks a leading zero in the hour tens digit.
module fnd_scan_drv
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_hour_bcd,
  input  logic [7:0] i_min_bcd,
  input  logic [7:0] i_sec_bcd,
  input  logic       i_dis_hour,
  input  logic       i_dis_min,
  input  logic       i_dis_sec,
  output logic [6:0] o_seg,
  output logic       o_seg_dp,
  output logic [5:0] o_seg_enb
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             w_tick;
  logic [3:0]       w_nibble;
  logic             w_field_en;
  logic             w_lead_zero;
  logic             w_blank;
  logic [6:0]       w_seg_dec;

  assign w_tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= SLOT_SEC_ONE;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick)
        r_idx <= (r_idx == SLOT_HOUR_TEN) ? SLOT_SEC_ONE : r_idx + 3'd1;
    end
  end

  always_comb begin
    w_nibble   = i_sec_bcd[3:0];
    w_field_en = i_dis_sec;
    case (r_idx)
      SLOT_SEC_ONE:  begin w_nibble = i_sec_bcd[3:0];  w_field_en = i_dis_sec;  end
      SLOT_SEC_TEN:  begin w_nibble = i_sec_bcd[7:4];  w_field_en = i_dis_sec;  end
      SLOT_MIN_ONE:  begin w_nibble = i_min_bcd[3:0];  w_field_en = i_dis_min;  end
      SLOT_MIN_TEN:  begin w_nibble = i_min_bcd[7:4];  w_field_en = i_dis_min;  end
      SLOT_HOUR_ONE: begin w_nibble = i_hour_bcd[3:0]; w_field_en = i_dis_hour; end
      SLOT_HOUR_TEN: begin w_nibble = i_hour_bcd[7:4]; w_field_en = i_dis_hour; end
      default:       begin w_nibble = i_sec_bcd[3:0];  w_field_en = i_dis_sec;  end
    endcase
  end

  seg7_dec u_seg7_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

`ifdef FND_LEAD_ZERO_BLANK_EN
  assign w_lead_zero = (r_idx == SLOT_HOUR_TEN) && (w_nibble == 4'd0);
`else
  assign w_lead_zero = 1'b0;
`endif

  // A tick cycle always emits a dark frame so the outgoing digit never ghosts onto the next anode.
  assign w_blank = w_tick || !w_field_en || w_lead_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_seg     <= SEG_OFF;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= ENB_ALL_OFF;
    end else if (w_blank) begin
      o_seg     <= SEG_OFF;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= ENB_ALL_OFF;
    end else begin
      o_seg     <= w_seg_dec;
      o_seg_dp  <= (r_idx == SLOT_MIN_ONE) || (r_idx == SLOT_HOUR_ONE);
      o_seg_enb <= ~(6'b000001 << r_idx);
    end
  end

endmodule

// File: tb/tb_fnd_scan_drv.sv
// Directed bench for fnd_scan_drv: one instance at SCAN_DIV=4, one at SCAN_DIV=2.
// Expected frames are {enb[5:0], seg[6:0], dp}; build with FND_LEAD_ZERO_BLANK_EN to check that variant.
module tb_fnd_scan_drv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_drv_if dif ();

  logic [6:0] seg2;
  logic       seg2Dp;
  logic [5:0] seg2Enb;

  int vecCnt = 0;
  int errCnt = 0;

  localparam logic [13:0] DEAD = {6'b111111, 7'b0000000, 1'b0};

  // Hand-decoded patterns for 12:34:56, indexed by slot
  logic [6:0] scanSeg [0:5];
  initial begin
    scanSeg[0] = 7'b1011111; // 6
    scanSeg[1] = 7'b1011011; // 5
    scanSeg[2] = 7'b0110011; // 4
    scanSeg[3] = 7'b1111001; // 3
    scanSeg[4] = 7'b1101101; // 2
    scanSeg[5] = 7'b0110000; // 1
  end

  fnd_scan_drv #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hour_bcd (dif.hour_bcd),
    .i_min_bcd  (dif.min_bcd),
    .i_sec_bcd  (dif.sec_bcd),
    .i_dis_hour (dif.dis_hour),
    .i_dis_min  (dif.dis_min),
    .i_dis_sec  (dif.dis_sec),
    .o_seg      (dif.seg),
    .o_seg_dp   (dif.seg_dp),
    .o_seg_enb  (dif.seg_enb)
  );

  fnd_scan_drv #(.SCAN_DIV(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hour_bcd (dif.hour_bcd),
    .i_min_bcd  (dif.min_bcd),
    .i_sec_bcd  (dif.sec_bcd),
    .i_dis_hour (dif.dis_hour),
    .i_dis_min  (dif.dis_min),
    .i_dis_sec  (dif.dis_sec),
    .o_seg      (seg2),
    .o_seg_dp   (seg2Dp),
    .o_seg_enb  (seg2Enb)
  );

  function automatic logic [13:0] litExp(input int slot, input logic [6:0] seg);
    logic [5:0] enb;
    logic       dp;
    enb = ~(6'b000001 << slot);
    dp  = (slot == 2) || (slot == 4);
    return {enb, seg, dp};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyDefaults;
    dif.hour_bcd = 8'h12;
    dif.min_bcd  = 8'h34;
    dif.sec_bcd  = 8'h56;
    dif.dis_hour = 1'b1;
    dif.dis_min  = 1'b1;
    dif.dis_sec  = 1'b1;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [13:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dif.hour_bcd = 8'h23 + 8'(i);
      dif.min_bcd  = 8'h59;
      dif.sec_bcd  = 8'h9A;
      dif.dis_hour = i[0];
      dif.dis_min  = 1'b1;
      dif.dis_sec  = 1'b1;
      step();
      got = {dif.seg_enb, dif.seg, dif.seg_dp};
      vecCnt++;
      if (got !== DEAD) begin
        errCnt++;
        $display("[TB] FAIL reset cyc=%0d got=%b exp=%b", i, got, DEAD);
      end
    end
    applyDefaults();
    rst_n = 1'b1;
    step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== litExp(0, scanSeg[0])) begin
      errCnt++;
      $display("[TB] FAIL reset_idx0 got=%b exp=%b", got, litExp(0, scanSeg[0]));
    end
  endtask

  task automatic test_scan_order;
    logic [13:0] got, exp;
    applyDefaults();
    doReset();
    for (int j = 1; j <= 28; j++) begin
      step();
      exp = ((j - 1) % 4 == 3) ? DEAD : litExp(((j - 1) / 4) % 6, scanSeg[((j - 1) / 4) % 6]);
      got = {dif.seg_enb, dif.seg, dif.seg_dp};
      vecCnt++;
      if (got !== exp) begin
        errCnt++;
        $display("[TB] FAIL scan j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_blink;
    logic [13:0] got, exp;
    int slot;
    applyDefaults();
    dif.dis_min = 1'b0;
    doReset();
    for (int j = 1; j <= 24; j++) begin
      step();
      slot = ((j - 1) / 4) % 6;
      if ((j - 1) % 4 == 3 || slot == 2 || slot == 3) exp = DEAD;
      else exp = litExp(slot, scanSeg[slot]);
      got = {dif.seg_enb, dif.seg, dif.seg_dp};
      vecCnt++;
      if (got !== exp) begin
        errCnt++;
        $display("[TB] FAIL blink_min j=%0d got=%b exp=%b", j, got, exp);
      end
    end
    // Mid-slot toggles, then a toggle landing on the tick edge
    applyDefaults();
    doReset();
    for (int j = 1; j <= 6; j++) begin
      case (j)
        2: dif.dis_sec = 1'b0;
        3: dif.dis_sec = 1'b1;
        4: dif.dis_sec = 1'b0;
        6: dif.dis_sec = 1'b1;
        default: ;
      endcase
      step();
      case (j)
        1, 3: exp = litExp(0, scanSeg[0]);
        6:    exp = litExp(1, scanSeg[1]);
        default: exp = DEAD;
      endcase
      got = {dif.seg_enb, dif.seg, dif.seg_dp};
      vecCnt++;
      if (got !== exp) begin
        errCnt++;
        $display("[TB] FAIL blink_toggle j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_invalid_bcd;
    logic [13:0] got;
    applyDefaults();
    dif.sec_bcd = 8'hA3;
    doReset();
    step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== litExp(0, 7'b1111001)) begin
      errCnt++;
      $display("[TB] FAIL bcd_ones got=%b exp=%b", got, litExp(0, 7'b1111001));
    end
    repeat (4) step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== litExp(1, 7'b0000001)) begin
      errCnt++;
      $display("[TB] FAIL bcd_dash got=%b exp=%b", got, litExp(1, 7'b0000001));
    end
    applyDefaults();
  endtask

  task automatic test_reset_mid_scan;
    logic [13:0] got, exp;
    applyDefaults();
    doReset();
    repeat (14) step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== litExp(3, scanSeg[3])) begin
      errCnt++;
      $display("[TB] FAIL midscan_pre got=%b exp=%b", got, litExp(3, scanSeg[3]));
    end
    rst_n = 1'b0;
    step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== DEAD) begin
      errCnt++;
      $display("[TB] FAIL midscan_rst got=%b exp=%b", got, DEAD);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      exp = ((j - 1) % 4 == 3) ? DEAD : litExp((j - 1) / 4, scanSeg[(j - 1) / 4]);
      got = {dif.seg_enb, dif.seg, dif.seg_dp};
      vecCnt++;
      if (got !== exp) begin
        errCnt++;
        $display("[TB] FAIL midscan_resume j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_min_div;
    logic [13:0] got, exp;
    applyDefaults();
    doReset();
    for (int j = 1; j <= 14; j++) begin
      step();
      exp = ((j - 1) % 2 == 1) ? DEAD : litExp(((j - 1) / 2) % 6, scanSeg[((j - 1) / 2) % 6]);
      got = {seg2Enb, seg2, seg2Dp};
      vecCnt++;
      if (got !== exp) begin
        errCnt++;
        $display("[TB] FAIL div2 j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_lead_zero;
    logic [13:0] got, exp;
    applyDefaults();
    dif.hour_bcd = 8'h07;
    doReset();
    repeat (17) step();
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== litExp(4, 7'b1110000)) begin
      errCnt++;
      $display("[TB] FAIL lead_ones got=%b exp=%b", got, litExp(4, 7'b1110000));
    end
    repeat (4) step();
`ifdef FND_LEAD_ZERO_BLANK_EN
    exp = DEAD;
`else
    exp = litExp(5, 7'b1111110);
`endif
    got = {dif.seg_enb, dif.seg, dif.seg_dp};
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("[TB] FAIL lead_tens got=%b exp=%b", got, exp);
    end
    applyDefaults();
  endtask

  initial begin
    applyDefaults();
    test_reset();
    test_scan_order();
    test_blink();
    test_invalid_bcd();
    test_reset_mid_scan();
    test_min_div();
    test_lead_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
